seq_tx: RTL and testbench

Serial pattern transmitter that drives the sequence detector's serial `din` input one bit per clock. It latches a parallel pattern of programmable length on a start strobe and shifts it out MSB-first with a per-bit valid flag, then signals completion. It serves as the on-chip stimulus source and loopback partner for the detector, replacing bench-driven bit streams.

---
 rtl/seq_tx.sv | 129 ++++++++++++
 tb/tb_seq_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - serial pattern transmitter, MSB-first, optional SEQ_TX_REPEAT_EN frame repeat
module seq_tx #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
`ifdef SEQ_TX_REPEAT_EN
  input  logic             repeat_frame,
`endif
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] eff_len;
  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] aligned;
  logic             accept;

  // Clamp the length and left-align the pattern so the first bit sits in the MSB
  always_comb begin
    eff_len = (len > WIDTH_C) ? WIDTH_C : len;
    shamt   = WIDTH_C - eff_len;
    aligned = pattern << shamt;
    accept  = start && (len != '0);
  end

`ifdef SEQ_TX_REPEAT_EN
  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] len_q;

  // Keep a copy of the accepted frame so it can be replayed without a gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= '0;
      len_q <= '0;
    end else if ((state == IDLE || state == DONE) && accept) begin
      pat_q <= aligned;
      len_q <= eff_len;
    end
  end
`endif

  // State, shift register and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and output decode; outputs depend only on registered state
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    dout     = 1'b0;
    valid    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SHIFT;
          sr_nx    = aligned;
          cnt_nx   = eff_len;
        end
      end
      SHIFT: begin
        dout  = sr[WIDTH-1];
        valid = 1'b1;
        busy  = 1'b1;
        if (cnt == CNT_W'(1)) begin
`ifdef SEQ_TX_REPEAT_EN
          if (repeat_frame) begin
            sr_nx  = pat_q;
            cnt_nx = len_q;
          end else begin
            state_nx = DONE;
            sr_nx    = '0;
            cnt_nx   = '0;
          end
`else
          state_nx = DONE;
          sr_nx    = '0;
          cnt_nx   = '0;
`endif
        end else begin
          sr_nx  = sr << 1;
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        done = 1'b1;
        // The exiting edge already behaves as IDLE so frames repeat every L+1 cycles
        if (accept) begin
          state_nx = SHIFT;
          sr_nx    = aligned;
          cnt_nx   = eff_len;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        sr_nx    = '0;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_tx.sv
// tb/tb_seq_tx.sv - directed self-checking bench for seq_tx
module tb_seq_tx;

  logic        clk;
  logic        rst;
  logic        start;
  logic [17:0] pattern;
  logic [4:0]  len;
  logic        dout;
  logic        valid;
  logic        busy;
  logic        done;
`ifdef SEQ_TX_REPEAT_EN
  logic        repeat_frame;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  seq_tx #(.WIDTH(18), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pattern      (pattern),
    .len          (len),
`ifdef SEQ_TX_REPEAT_EN
    .repeat_frame (repeat_frame),
`endif
    .dout         (dout),
    .valid        (valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".dout"},  {31'd0, dout},  32'd0);
    check({tag, ".valid"}, {31'd0, valid}, 32'd0);
    check({tag, ".busy"},  {31'd0, busy},  32'd0);
    check({tag, ".done"},  {31'd0, done},  32'd0);
  endtask

  // Sends one frame; exp_bits holds the hand-written frame, first bit in exp_bits[n-1]
  task automatic run_frame(input string tag, input logic [17:0] pat, input logic [4:0] l,
                           input logic [17:0] exp_bits, input int n);
    pattern = pat;
    len     = l;
    start   = 1'b1;
    step();
    start   = 1'b0;
    pattern = ~pat;
    len     = 5'd1;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s.bit%0d.dout", tag, k), {31'd0, dout}, {31'd0, exp_bits[n-1-k]});
      check($sformatf("%s.bit%0d.valid", tag, k), {31'd0, valid}, 32'd1);
      check($sformatf("%s.bit%0d.busy", tag, k), {31'd0, busy}, 32'd1);
      check($sformatf("%s.bit%0d.done", tag, k), {31'd0, done}, 32'd0);
      step();
    end
    check({tag, ".done"},       {31'd0, done},  32'd1);
    check({tag, ".done_valid"}, {31'd0, valid}, 32'd0);
    check({tag, ".done_busy"},  {31'd0, busy},  32'd0);
    check({tag, ".done_dout"},  {31'd0, dout},  32'd0);
    step();
    check_idle({tag, ".after"});
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
`ifdef SEQ_TX_REPEAT_EN
    repeat_frame = 1'b0;
`endif
    #1;
    check_idle("reset");
    step();
    check_idle("reset_clk");
    @(negedge clk);
    rst = 1'b1;
    step();
    check_idle("post_reset");

    run_frame("full", 18'b11_0010_0100_0010_0101, 5'd18, 18'b11_0010_0100_0010_0101, 18);
    run_frame("short", 18'h0000B, 5'd4, 18'h0000B, 4);
    run_frame("len25", 18'h2A5F3, 5'd25, 18'h2A5F3, 18);

    // len = 0 is ignored
    pattern = 18'h3FFFF;
    len     = 5'd0;
    start   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("len0.c%0d", i));
    end
    start = 1'b0;

    // start held high, len = 3, pattern 101: a frame every 4 cycles
    pattern = 18'h00005;
    len     = 5'd3;
    start   = 1'b1;
    step();
    for (int f = 0; f < 3; f++) begin
      check($sformatf("cont.f%0d.b0", f), {31'd0, dout}, 32'd1);
      check($sformatf("cont.f%0d.v0", f), {31'd0, valid}, 32'd1);
      step();
      check($sformatf("cont.f%0d.b1", f), {31'd0, dout}, 32'd0);
      check($sformatf("cont.f%0d.v1", f), {31'd0, valid}, 32'd1);
      step();
      check($sformatf("cont.f%0d.b2", f), {31'd0, dout}, 32'd1);
      check($sformatf("cont.f%0d.d2", f), {31'd0, done}, 32'd0);
      step();
      check($sformatf("cont.f%0d.done", f), {31'd0, done}, 32'd1);
      check($sformatf("cont.f%0d.busy", f), {31'd0, busy}, 32'd0);
      if (f == 2) start = 1'b0;
      step();
    end
    check_idle("cont.end");

    // asynchronous reset during bit 7 of an 18-bit frame
    pattern = 18'b11_0010_0100_0010_0101;
    len     = 5'd18;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("rst.bit7.dout",  {31'd0, dout},  32'd1);
    check("rst.bit7.valid", {31'd0, valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_idle("rst.async");
    step();
    check_idle("rst.held1");
    step();
    check_idle("rst.held2");
    @(negedge clk);
    rst = 1'b1;
    step();
    check_idle("rst.release");
    run_frame("after_rst", 18'b11_0010_0100_0010_0101, 5'd18, 18'b11_0010_0100_0010_0101, 18);

`ifdef SEQ_TX_REPEAT_EN
    // repeat for two extra frames, then end normally
    pattern      = 18'b1011;
    len          = 5'd4;
    repeat_frame = 1'b1;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      logic [3:0] ref_bits;
      ref_bits = 4'b1011;
      if (k >= 8) repeat_frame = 1'b0;
      check($sformatf("rep.bit%0d.dout", k), {31'd0, dout}, {31'd0, ref_bits[3 - (k % 4)]});
      check($sformatf("rep.bit%0d.busy", k), {31'd0, busy}, 32'd1);
      step();
    end
    check("rep.done", {31'd0, done}, 32'd1);
    step();
    check_idle("rep.end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
